// File: rtl/wb_commit_unit_pkg.sv
// Shared definitions for the register-file writeback/commit slice.
//   ADDR_W_DEF / DATA_W_DEF : default register index and data widths
//   ZERO_REG                : hardwired-zero register index
//   src_e                   : result source encoding (ALU / LSU)
package wb_commit_unit_pkg;

  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ZERO_REG   = 0;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/wb_commit_unit_arb.sv
// wb_rr_arbiter: two-requester round-robin arbiter (ALU vs LSU).
//   clk, resetn        : clock, async active-low reset
//   req_alu, req_lsu   : requests (result valids)
//   gnt_alu, gnt_lsu   : combinational grants, at most one high
// A lone request always wins. On a two-way contest the pointer source wins
// and the pointer then moves to the other source.
module wb_rr_arbiter
  import wb_commit_unit_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic req_alu,
  input  logic req_lsu,
  output logic gnt_alu,
  output logic gnt_lsu
);

  src_e ptr;

  always_comb begin
    gnt_alu = req_alu & (~req_lsu | (ptr == SRC_ALU));
    gnt_lsu = req_lsu & (~req_alu | (ptr == SRC_LSU));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr <= SRC_ALU;
    end else if (req_alu & req_lsu) begin
      ptr <= (ptr == SRC_ALU) ? SRC_LSU : SRC_ALU;
    end
  end

endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: writer side of the register file.
//   Arbitrates ALU/LSU results onto the single write port (rf_we/rf_waddr/
//   rf_wdata, one cycle latency), tracks pending writes for decode hazard
//   checks (iss_*, rsN_busy) and offers a same-cycle bypass (rsN_fwd,
//   fwd_data) because a regfile read returns the old value during a write.
//   err is sticky: a result arrived for a register that was not pending.
//   flush clears the scoreboard; in-flight writes still complete.
module wb_commit_unit
  import wb_commit_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dest,
  output logic              iss_ready,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [ADDR_W-1:0] lsu_dest,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              rs1_fwd,
  output logic              rs2_fwd,
  output logic [DATA_W-1:0] fwd_data,
  output logic              err
);

  localparam int unsigned         NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0]   ZIDX = ADDR_W'(ZERO_REG);

  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pend_set;
  logic [NREG-1:0]   pend_clr;
  logic              acc;
  logic [ADDR_W-1:0] acc_dest;
  logic [DATA_W-1:0] acc_data;

  wb_rr_arbiter u_arb (
    .clk     (clk),
    .resetn  (resetn),
    .req_alu (alu_valid),
    .req_lsu (lsu_valid),
    .gnt_alu (alu_ready),
    .gnt_lsu (lsu_ready)
  );

  always_comb begin
    acc      = alu_ready | lsu_ready;
    acc_dest = lsu_ready ? lsu_dest : alu_dest;
    acc_data = lsu_ready ? lsu_data : alu_data;
  end

  always_comb begin
    // A register being written this cycle is free for a new issue.
    iss_ready = ~pending[iss_dest] | (rf_we & (rf_waddr == iss_dest)) |
                (iss_dest == ZIDX);
    rs1_fwd   = rf_we & (rf_waddr == rs1) & (rs1 != ZIDX);
    rs2_fwd   = rf_we & (rf_waddr == rs2) & (rs2 != ZIDX);
    rs1_busy  = pending[rs1] & ~rs1_fwd;
    rs2_busy  = pending[rs2] & ~rs2_fwd;
    fwd_data  = rf_wdata;
    pend_set  = '0;
    pend_clr  = '0;
    if (iss_valid & iss_ready & ~flush & (iss_dest != ZIDX)) begin
      pend_set[iss_dest] = 1'b1;
    end
    if (rf_we) begin
      pend_clr[rf_waddr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      pending  <= '0;
      err      <= 1'b0;
    end else begin
      rf_we <= acc & (acc_dest != ZIDX);
      if (acc) begin
        rf_waddr <= acc_dest;
        rf_wdata <= acc_data;
      end
      // Set is applied after clear so a same-index set wins.
      pending <= flush ? '0 : ((pending & ~pend_clr) | pend_set);
      if (acc & (acc_dest != ZIDX) & ~pending[acc_dest]) begin
        err <= 1'b1;
      end
    end
  end

endmodule
